// File: rtl/led_seq_ctrl.sv
// LED pattern sequencer: walks a ROM address range at a programmable step rate
// and registers the returned pattern onto the LEDs, with pause/step/loop control.
module led_seq_ctrl #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8,
  parameter int DIV_W  = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic              step,
  input  logic              dir,
  input  logic              loop,
  input  logic [ADDR_W-1:0] addr_lo,
  input  logic [ADDR_W-1:0] addr_hi,
  input  logic [DIV_W-1:0]  div_val,
  input  logic [DATA_W-1:0] rom_q,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [DATA_W-1:0] led,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [DIV_W-1:0]  DIV_ONE  = DIV_W'(1);

  state_t              state;
  state_t              state_nxt;
  logic                dir_q;
  logic                loop_q;
  logic [ADDR_W-1:0]   lo_q;
  logic [ADDR_W-1:0]   hi_q;
  logic [DIV_W-1:0]    div_q;
  logic [DIV_W-1:0]    tick_cnt;
  logic [DIV_W-1:0]    cnt_nxt;
  logic [DIV_W-1:0]    div_last;
  logic [1:0]          ld_pipe;
  logic [ADDR_W-1:0]   addr_nxt;
  logic                addr_load;
  logic                busy_nxt;
  logic                done_nxt;
  logic                err_nxt;

  logic cmd_start, cmd_pause, cmd_step;
  logic range_ok, tick, advance, at_end, finish, run_free;

  // Only the highest-priority pulse of a cycle survives decoding
  assign cmd_start = start & ~stop;
  assign cmd_pause = pause & ~stop & ~start;
  assign cmd_step  = step & ~stop & ~start & ~pause;

  assign range_ok = (addr_lo <= addr_hi);
  assign div_last = (div_q == '0) ? '0 : (div_q - DIV_ONE);
  assign run_free = (state == RUN) && !stop && !cmd_start && !cmd_pause;
  assign tick     = (state == RUN) && (tick_cnt == div_last);
  assign advance  = (run_free && tick) || ((state == PAUSE) && cmd_step);
  assign at_end   = dir_q ? (rom_addr == lo_q) : (rom_addr == hi_q);
  assign finish   = advance && at_end && !loop_q;

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (stop) begin
      state_nxt = IDLE;
    end else if (cmd_start) begin
      state_nxt = range_ok ? RUN : IDLE;
    end else if (finish) begin
      state_nxt = IDLE;
    end else if (cmd_pause) begin
      case (state)
        RUN:     state_nxt = PAUSE;
        PAUSE:   state_nxt = RUN;
        default: state_nxt = state;
      endcase
    end
  end

  always_comb begin
    addr_load = 1'b0;
    addr_nxt  = rom_addr;
    cnt_nxt   = tick_cnt;
    busy_nxt  = (state_nxt != IDLE);
    done_nxt  = finish;
    err_nxt   = cmd_start && !range_ok;
    if (cmd_start && range_ok) begin
      addr_load = 1'b1;
      addr_nxt  = dir ? addr_hi : addr_lo;
      cnt_nxt   = '0;
    end else begin
      // The final address of a one-shot is held, so finishing is not a load
      if (advance && !finish) begin
        addr_load = 1'b1;
        if (at_end) begin
          addr_nxt = dir_q ? hi_q : lo_q;
        end else begin
          addr_nxt = dir_q ? (rom_addr - ADDR_ONE) : (rom_addr + ADDR_ONE);
        end
      end
      if (run_free) begin
        cnt_nxt = tick ? '0 : (tick_cnt + DIV_ONE);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      rom_addr <= '0;
      led      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      tick_cnt <= '0;
      dir_q    <= 1'b0;
      loop_q   <= 1'b0;
      lo_q     <= '0;
      hi_q     <= '0;
      div_q    <= '0;
      ld_pipe  <= '0;
    end else begin
      rom_addr <= addr_nxt;
      tick_cnt <= cnt_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      err      <= err_nxt;
      if (cmd_start && range_ok) begin
        dir_q  <= dir;
        loop_q <= loop;
        lo_q   <= addr_lo;
        hi_q   <= addr_hi;
        div_q  <= div_val;
      end
      // One stage for the ROM address register, one for its data output
      ld_pipe <= {ld_pipe[0], addr_load};
      if (ld_pipe[1]) begin
        led <= rom_q;
      end
    end
  end

endmodule
